// File: rtl/match_controller_if.sv
// Signal bundle between the match sequencer and its neighbours: the start
// and abort controls, the scoring block (goal pulse, scores, clear) and the
// display/actuator side (countdown, play enable, match over, winner, debug).
//
// Timing contract: every signal is a plain level sampled or updated on the
// rising clock edge. There is no valid/ready pairing. i_goal and
// o_score_clear are single-cycle pulses. Every other signal is a level.
interface match_controller_if;
  logic        i_start;
  logic        i_abort;
  logic        i_goal;
  logic [7:0]  i_score_P1;
  logic [7:0]  i_score_P2;
  logic        o_score_clear;
  logic        o_countdown;
  logic        o_play_en;
  logic        o_match_over;
  logic [1:0]  o_winner;
  logic [31:0] o_debug;

  // Sequencer side
  modport slave (
    input  i_start, i_abort, i_goal, i_score_P1, i_score_P2,
    output o_score_clear, o_countdown, o_play_en, o_match_over, o_winner, o_debug
  );

  // Environment side (buttons, scoring block, display)
  modport master (
    output i_start, i_abort, i_goal, i_score_P1, i_score_P2,
    input  o_score_clear, o_countdown, o_play_en, o_match_over, o_winner, o_debug
  );
endinterface

// File: rtl/match_controller.sv
// Match sequencer for the puck/ball table. It clears the scoring block and
// runs a serve countdown. It then enables play until a goal arrives, holds
// off after each goal, and declares a winner once either score reaches
// WinScore.
// All outputs are decoded from registered state only. The scores shown on
// o_debug are taken through a register, so nothing passes combinationally
// from an input to an output.
module match_controller #(
  parameter logic [7:0]  WinScore        = 8'd7,
  parameter logic [31:0] CountdownCycles = 32'd150000000,
  parameter logic [31:0] GoalHoldCycles  = 32'd60000000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  match_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    s_Idle      = 3'b000,
    s_Clear     = 3'b001,
    s_Countdown = 3'b010,
    s_Play      = 3'b011,
    s_GoalHold  = 3'b100,
    s_Over      = 3'b101
  } state_t;

  // Terminal counts, computed once at full counter width
  localparam logic [31:0] CountdownLast = CountdownCycles - 32'd1;
  localparam logic [31:0] GoalHoldLast  = GoalHoldCycles - 32'd1;

  state_t      state_q;
  logic [31:0] count_q;
  logic [1:0]  winner_q;
  logic [7:0]  score_p1_q;
  logic [7:0]  score_p2_q;

  logic        p1_reached;
  logic        p2_reached;
  logic        count_cd_done;
  logic        count_hold_done;

  // Target comparison against the live scores; only used at the end of the hold
  assign p1_reached      = (bus.i_score_P1 >= WinScore);
  assign p2_reached      = (bus.i_score_P2 >= WinScore);
  assign count_cd_done   = (count_q == CountdownLast);
  assign count_hold_done = (count_q == GoalHoldLast);

  // Main sequencer. Reset wins over everything. Abort wins over goal and start in every state except idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= s_Idle;
      count_q  <= 32'd0;
      winner_q <= 2'b00;
    end else if (bus.i_abort && (state_q != s_Idle)) begin
      state_q  <= s_Idle;
      count_q  <= 32'd0;
      winner_q <= 2'b00;
    end else begin
      case (state_q)
        s_Idle: begin
          if (bus.i_start) begin
            state_q <= s_Clear;
          end
        end
        s_Clear: begin
          winner_q <= 2'b00;
          count_q  <= 32'd0;
          state_q  <= s_Countdown;
        end
        s_Countdown: begin
          if (count_cd_done) begin
            count_q <= 32'd0;
            state_q <= s_Play;
          end else begin
            count_q <= count_q + 32'd1;
          end
        end
        s_Play: begin
          // A goal ends the rally; start requests are meaningless mid-play
          if (bus.i_goal) begin
            count_q <= 32'd0;
            state_q <= s_GoalHold;
          end
        end
        s_GoalHold: begin
          // Further goal pulses are ignored; only the hold timer matters
          if (count_hold_done) begin
            count_q <= 32'd0;
            if (p1_reached || p2_reached) begin
              winner_q <= {p2_reached, p1_reached};
              state_q  <= s_Over;
            end else begin
              state_q  <= s_Countdown;
            end
          end else begin
            count_q <= count_q + 32'd1;
          end
        end
        s_Over: begin
          // A start held high from earlier presses restarts immediately; intended
          if (bus.i_start) begin
            state_q <= s_Clear;
          end
        end
        default: begin
          state_q <= s_Idle;
          count_q <= 32'd0;
        end
      endcase
    end
  end

  // Registered copy of the scores shown on the debug word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      score_p1_q <= 8'd0;
      score_p2_q <= 8'd0;
    end else begin
      score_p1_q <= bus.i_score_P1;
      score_p2_q <= bus.i_score_P2;
    end
  end

  assign bus.o_score_clear = (state_q == s_Clear);
  assign bus.o_countdown   = (state_q == s_Countdown);
  assign bus.o_play_en     = (state_q == s_Play);
  assign bus.o_match_over  = (state_q == s_Over);
  assign bus.o_winner      = winner_q;
  assign bus.o_debug       = {score_p2_q, score_p1_q, 6'd0, winner_q, 5'd0, state_q};

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller. It uses a short countdown (4) and a
// short hold (3), with a winning score of 7.
module tb_match_controller;
  localparam logic [7:0]  WIN = 8'd7;
  localparam int          CD  = 4;
  localparam int          GH  = 3;

  localparam int M_IDLE = 0, M_CLEAR = 1, M_CD = 2, M_PLAY = 3, M_HOLD = 4, M_OVER = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   chk_en;

  match_controller_if bus();

  match_controller #(
    .WinScore(WIN),
    .CountdownCycles(32'(CD)),
    .GoalHoldCycles(32'(GH))
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The model tracks the match phase and the number of cycles left in it.
  int         m_mode;
  int         m_rem;
  logic [1:0] m_win;
  logic [7:0] m_sp1, m_sp2;

  function automatic logic [2:0] code_of(input int mode);
    case (mode)
      M_CLEAR: code_of = 3'b001;
      M_CD:    code_of = 3'b010;
      M_PLAY:  code_of = 3'b011;
      M_HOLD:  code_of = 3'b100;
      M_OVER:  code_of = 3'b101;
      default: code_of = 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    m_sp1 <= bus.i_score_P1;
    m_sp2 <= bus.i_score_P2;
    if (rst) begin
      m_mode <= M_IDLE; m_rem <= 0; m_win <= 2'b00; m_sp1 <= 8'd0; m_sp2 <= 8'd0;
    end else if (bus.i_abort && m_mode != M_IDLE) begin
      m_mode <= M_IDLE; m_win <= 2'b00;
    end else begin
      case (m_mode)
        M_IDLE:  if (bus.i_start) m_mode <= M_CLEAR;
        M_CLEAR: begin m_win <= 2'b00; m_mode <= M_CD; m_rem <= CD; end
        M_CD:    if (m_rem == 1) m_mode <= M_PLAY; else m_rem <= m_rem - 1;
        M_PLAY:  if (bus.i_goal) begin m_mode <= M_HOLD; m_rem <= GH; end
        M_HOLD: begin
          if (m_rem == 1) begin
            if (bus.i_score_P1 >= WIN || bus.i_score_P2 >= WIN) begin
              m_mode <= M_OVER;
              m_win  <= {bus.i_score_P2 >= WIN, bus.i_score_P1 >= WIN};
            end else begin
              m_mode <= M_CD; m_rem <= CD;
            end
          end else begin
            m_rem <= m_rem - 1;
          end
        end
        M_OVER:  if (bus.i_start) m_mode <= M_CLEAR;
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("score_clear", 32'(bus.o_score_clear), 32'(m_mode == M_CLEAR));
      check("countdown",   32'(bus.o_countdown),   32'(m_mode == M_CD));
      check("play_en",     32'(bus.o_play_en),     32'(m_mode == M_PLAY));
      check("match_over",  32'(bus.o_match_over),  32'(m_mode == M_OVER));
      check("winner",      32'(bus.o_winner),      32'(m_win));
      check("debug",       bus.o_debug, {m_sp2, m_sp1, 6'd0, m_win, 5'd0, code_of(m_mode)});
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_goal();
    bus.i_goal = 1'b1;
    @(negedge clk);
    bus.i_goal = 1'b0;
  endtask

  // Count clear/countdown/other cycles until play_en (or match_over) is seen
  task automatic measure(input bit want_over, output int n_clr, output int n_cd, output int n_oth);
    n_clr = 0; n_cd = 0; n_oth = 0;
    for (int i = 0; i < 40; i++) begin
      if (want_over ? bus.o_match_over : bus.o_play_en) return;
      if (bus.o_score_clear) n_clr++;
      else if (bus.o_countdown) n_cd++;
      else n_oth++;
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL measure_timeout actual=no_target expected=target_within_40_cycles");
  endtask

  // ---------------- directed sequence ----------------
  int n_clr, n_cd, n_oth;

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_goal = 1'b0;
    bus.i_score_P1 = 8'd0; bus.i_score_P2 = 8'd0;
    checks = 0; failures = 0; chk_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset_debug", bus.o_debug, 32'h0);
    check("reset_outs", {27'd0, bus.o_score_clear, bus.o_countdown, bus.o_play_en,
                         bus.o_match_over, bus.o_winner != 2'b00}, 32'h0);

    // Basic start
    @(negedge clk);
    pulse_start();
    measure(1'b0, n_clr, n_cd, n_oth);
    check("start_clr_cycles", 32'(n_clr), 32'd1);
    check("start_cd_cycles",  32'(n_cd),  32'd4);
    check("start_other",      32'(n_oth), 32'd0);
    check("start_state",      32'(bus.o_debug[2:0]), 32'h3);

    // Goal without a win
    bus.i_score_P1 = 8'd1; bus.i_score_P2 = 8'd0;
    pulse_goal();
    check("goal_play_drop", 32'(bus.o_play_en), 32'd0);
    measure(1'b0, n_clr, n_cd, n_oth);
    check("goal_hold_cycles", 32'(n_oth), 32'd3);
    check("goal_cd_cycles",   32'(n_cd),  32'd4);
    check("goal_winner",      32'(bus.o_winner), 32'd0);

    // Match win for P1
    bus.i_score_P1 = 8'd7; bus.i_score_P2 = 8'd3;
    pulse_goal();
    measure(1'b1, n_clr, n_cd, n_oth);
    check("win_hold_cycles", 32'(n_oth), 32'd3);
    check("win_debug",  bus.o_debug, 32'h0307_0105);
    check("win_winner", 32'(bus.o_winner), 32'd1);
    bus.i_score_P1 = 8'd0; bus.i_score_P2 = 8'd0;
    pulse_start();
    check("restart_clear", 32'(bus.o_score_clear), 32'd1);
    measure(1'b0, n_clr, n_cd, n_oth);
    check("restart_cd_cycles", 32'(n_cd), 32'd4);
    check("restart_winner",    32'(bus.o_winner), 32'd0);

    // Goal and abort together: abort wins
    bus.i_goal = 1'b1; bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_goal = 1'b0; bus.i_abort = 1'b0;
    check("abort_state", 32'(bus.o_debug[2:0]), 32'h0);
    pulse_start();
    measure(1'b0, n_clr, n_cd, n_oth);
    // Goal and start together: goal wins
    bus.i_goal = 1'b1; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_goal = 1'b0; bus.i_start = 1'b0;
    check("goal_start_state", 32'(bus.o_debug[2:0]), 32'h4);
    measure(1'b0, n_clr, n_cd, n_oth);
    check("goal_start_hold", 32'(n_oth), 32'd3);

    // Reset in the middle of the countdown (count 2)
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    pulse_start();           // now in clear
    @(negedge clk);          // count 0
    @(negedge clk);          // count 1
    @(negedge clk);          // count 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_debug", bus.o_debug, 32'h0);
    check("midreset_cd", 32'(bus.o_countdown), 32'd0);
    pulse_start();
    measure(1'b0, n_clr, n_cd, n_oth);
    check("midreset_clr_cycles", 32'(n_clr), 32'd1);
    check("midreset_cd_cycles",  32'(n_cd),  32'd4);

    // Both reach the target, with extra goal pulses during the hold
    bus.i_score_P1 = 8'd7; bus.i_score_P2 = 8'd7;
    pulse_goal();            // hold cycle 1
    pulse_goal();            // hold cycle 2
    pulse_goal();            // hold cycle 3
    measure(1'b1, n_clr, n_cd, n_oth);
    check("both_hold_rest", 32'(n_oth), 32'd1);
    check("both_winner", 32'(bus.o_winner), 32'd3);
    check("both_over",   32'(bus.o_match_over), 32'd1);
    check("both_debug",  bus.o_debug, 32'h0707_0305);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Top-level game sequencer for the puck/ball table. It arms the scoring block, gates puck-release and play, inserts a countdown before each serve and a hold-off after each goal, and declares the match winner once a score reaches the target. Sits between the user start button, the scoring FSM (goal pulse, 8-bit scores, reset) and the display/actuator logic.

Parameters:
WinScore, 8'd7, score that ends the match (compare is >=).
CountdownCycles, 32'd150000000, serve countdown length in clocks (min 1).
GoalHoldCycles, 32'd60000000, post-goal hold-off in clocks (min 1).

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start/restart request, level, sampled each clock
i_abort  in  1  abort match, level, sampled each clock
i_goal  in  1  one-cycle goal pulse from scoring block; scores already updated when high
i_score_P1  in  8  P1 score from scoring block
i_score_P2  in  8  P2 score from scoring block
o_score_clear  out  1  one-cycle reset pulse to scoring block
o_countdown  out  1  high during serve countdown
o_play_en  out  1  high while puck is live (enables release/tracking)
o_match_over  out  1  high in s_Over
o_winner  out  2  00 none, 01 P1, 10 P2, 11 both reached target
o_debug  out  32  {i_score_P2, i_score_P1, 6'd0, o_winner, 5'd0, r_state}

Behaviour:
- Reset (synchronous, i_reset=1 at clock edge): r_state=s_Idle, counter=0, o_winner=00; all outputs 0. Reset overrides any other input and any state, including mid-countdown or mid-hold.
- All outputs registered or decoded from registered state only; no combinational input-to-output paths.
- States (3-bit): s_Idle=000, s_Clear=001, s_Countdown=010, s_Play=011, s_GoalHold=100, s_Over=101; unused codes -> s_Idle next cycle.
- s_Idle: i_start=1 -> s_Clear; otherwise stay.
- s_Clear: o_score_clear=1 for exactly this one cycle; o_winner<=00; counter<=0; -> s_Countdown.
- s_Countdown: o_countdown=1.
  - counter increments each cycle.
  - When counter==CountdownCycles-1: -> s_Play, counter<=0.
  - Duration is exactly CountdownCycles cycles.
- s_Play: o_play_en=1.
  - i_goal=1 -> s_GoalHold, counter<=0.
  - i_goal has priority over i_start; i_start is ignored in s_Play.
- s_GoalHold: o_play_en=0; counter increments.
  - When counter==GoalHoldCycles-1, evaluate i_score_P1/i_score_P2 against WinScore in that cycle:
    - either score >= WinScore -> s_Over; o_winner<={P2>=Win, P1>=Win}.
    - otherwise -> s_Countdown, counter<=0.
  - Further i_goal pulses during the hold are ignored.
- s_Over: o_match_over=1; o_winner held.
  - i_start=1 -> s_Clear, which starts a new match and clears o_winner.
  - i_start held high continuously from a previous press restarts as soon as s_Over is entered; this is intended.
- i_abort=1 in any state except s_Idle -> s_Idle next cycle; counter<=0; o_winner<=00. No o_score_clear pulse is issued. i_abort beats i_goal and i_start in the same cycle.
- Counter is 32-bit unsigned and never wraps in normal use. Comparison is equality to Param-1, computed at 32 bits.
- WinScore=0: the first goal hold ends the match.

Test Plan:
- Basic start: CountdownCycles=4, GoalHoldCycles=3; reset, then i_start=1 for 1 cycle -> o_score_clear high for exactly 1 cycle; o_countdown high for 4 cycles; o_play_en rises on the next cycle; o_debug[2:0]=011.
- Goal, no win: in s_Play pulse i_goal with scores 1/0, WinScore=7 -> o_play_en falls the next cycle; after 3 hold cycles o_countdown high for 4 cycles, then o_play_en=1 again; o_winner=00.
- Match win: drive i_score_P1=7, i_score_P2=3 and pulse i_goal -> after hold, o_match_over=1, o_winner=01, o_debug={8'd3,8'd7,6'd0,2'b01,5'd0,3'b101}. Then i_start -> o_score_clear pulse, o_winner=00.
- Simultaneous inputs: i_goal and i_abort in the same s_Play cycle -> next state s_Idle, no hold. i_goal and i_start together in s_Play -> s_GoalHold.
- Reset mid-operation: assert i_reset at countdown count 2 -> next cycle all outputs 0, state 000. After deassert, i_start restarts the full 4-cycle countdown.
- Both reach target: scores 7/7 at hold end -> o_winner=11, o_match_over=1. Extra i_goal pulses during the hold -> no effect on timing.
